// File: rtl/thread_out_fifo.sv
// thread_out_fifo: per-thread packet buffer (in: in_data/in_ctrl/in_wr/in_rdy, arbiter: start_read/read_done/thread_done, out: out_data/out_ctrl/out_wr/out_rdy, status: overflow/pkt_count; pkt_count enabled by THREAD_OUT_FIFO_PKT_COUNT_EN)
module thread_out_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic                  thread_done,
  input  logic                  start_read,
  input  logic                  read_done,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  output logic                  overflow,
  output logic [15:0]           pkt_count
);
  typedef enum logic [1:0] {FILL, READY, DRAIN, WAIT_DONE} state_t;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;
  state_t state_q, state_d;
  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic in_payload_q, in_payload_d, eop_read_q, eop_read_d;
  logic thread_done_q, thread_done_d, out_wr_q, out_wr_d, overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;
  logic [CTRL_WIDTH+DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic full, empty, wr_en, eop_wr, rd_en;
  assign full   = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) && (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
  assign empty  = wr_ptr_q == rd_ptr_q;
  assign wr_en  = state_q == FILL && in_wr && !full;
  assign eop_wr = wr_en && in_ctrl != '0 && in_payload_q;
  assign rd_en  = state_q == DRAIN && out_rdy && !empty && !eop_read_q;
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d      = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    in_payload_d  = wr_en ? in_ctrl == '0 : in_payload_q;
    eop_read_d    = eop_read_q | (rd_en && rd_ptr_q == wr_ptr_q - PTR_ONE);
    thread_done_d = eop_wr;
    out_wr_d      = rd_en;
    {out_ctrl_d, out_data_d} = rd_en ? mem[rd_ptr_q[ADDR_WIDTH-1:0]] : {out_ctrl_q, out_data_q};
    overflow_d    = overflow_q | (state_q == FILL && in_wr && full);
    case (state_q)
      FILL:      state_d = eop_wr ? READY : FILL;
      READY:     state_d = start_read ? DRAIN : READY;
      DRAIN:     state_d = eop_read_q ? WAIT_DONE : DRAIN;
      WAIT_DONE: if (read_done) begin
        state_d      = FILL;
        wr_ptr_d     = '0;
        rd_ptr_d     = '0;
        eop_read_d   = 1'b0;
        in_payload_d = 1'b0;
      end
      default:   state_d = FILL;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= FILL;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      in_payload_q  <= 1'b0;
      eop_read_q    <= 1'b0;
      thread_done_q <= 1'b0;
      out_wr_q      <= 1'b0;
      overflow_q    <= 1'b0;
      out_data_q    <= '0;
      out_ctrl_q    <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      in_payload_q  <= in_payload_d;
      eop_read_q    <= eop_read_d;
      thread_done_q <= thread_done_d;
      out_wr_q      <= out_wr_d;
      overflow_q    <= overflow_d;
      out_data_q    <= out_data_d;
      out_ctrl_q    <= out_ctrl_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= {in_ctrl, in_data};
  end
  assign in_rdy      = state_q == FILL && !full;
  assign thread_done = thread_done_q;
  assign out_wr      = out_wr_q;
  assign out_data    = out_data_q;
  assign out_ctrl    = out_ctrl_q;
  assign overflow    = overflow_q;
`ifdef THREAD_OUT_FIFO_PKT_COUNT_EN
  logic [15:0] pkt_count_q, pkt_count_d;
  always_comb pkt_count_d = (state_q == DRAIN && eop_read_q) ? pkt_count_q + 16'd1 : pkt_count_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pkt_count_q <= '0;
    else pkt_count_q <= pkt_count_d;
  end
  assign pkt_count = pkt_count_q;
`else
  assign pkt_count = '0;
`endif
endmodule
